// File: rtl/debug_dump_sequencer.sv
// Streams PC, register file and data memory out as UART bytes (LSB first) after a halt.
// One byte in flight at a time: strobe, then wait for tx_done before the next byte.
module debug_dump_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int ADDR_WIDTH      = 5,
  parameter int N_REGS          = 32,
  parameter int N_MEM           = 32
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [ADDR_WIDTH-1:0]      o_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_reg_data,
  output logic [ADDR_WIDTH-1:0]      o_mem_addr,
  input  logic [DATA_WIDTH-1:0]      i_mem_data,
  input  logic                       i_tx_available,
  input  logic                       i_tx_done,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int IDX_MAX = (N_REGS > N_MEM) ? N_REGS : N_MEM;
  localparam int IDX_W   = $clog2(IDX_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_SEND, S_WAIT, S_NEXT, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_PC, PH_REG, PH_MEM} phase_t;

  state_t                state;
  phase_t                phase;
  logic [DATA_WIDTH-1:0] word_buf;
  logic [1:0]            byte_cnt;
  logic [IDX_W-1:0]      word_idx;

  // The low byte of the shift buffer is the byte on the wire; it only moves in NEXT/CAPTURE.
  assign o_tx_byte = word_buf[DATA_WIDTH_UART-1:0];

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= S_IDLE;
      phase       <= PH_PC;
      word_buf    <= '0;
      byte_cnt    <= '0;
      word_idx    <= '0;
      o_reg_addr  <= '0;
      o_mem_addr  <= '0;
      o_tx_signal <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_tx_signal <= 1'b0;
      o_done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            word_buf <= i_pc;
            phase    <= PH_PC;
            byte_cnt <= '0;
            word_idx <= '0;
            o_busy   <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_FETCH: state <= S_CAPTURE;
        S_CAPTURE: begin
          word_buf <= (phase == PH_MEM) ? i_mem_data : i_reg_data;
          byte_cnt <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (i_tx_available) begin
            o_tx_signal <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_tx_done) state <= S_NEXT;
        end
        S_NEXT: begin
          word_buf <= word_buf >> DATA_WIDTH_UART;
          byte_cnt <= byte_cnt + 2'd1;
          if (byte_cnt != 2'd3) begin
            state <= S_SEND;
          end else begin
            // Read addresses are set on entry to FETCH so read data is ready by CAPTURE.
            case (phase)
              PH_PC: begin
                phase      <= PH_REG;
                word_idx   <= '0;
                o_reg_addr <= '0;
                state      <= S_FETCH;
              end
              PH_REG: begin
                if (word_idx == IDX_W'(N_REGS - 1)) begin
                  phase      <= PH_MEM;
                  word_idx   <= '0;
                  o_mem_addr <= '0;
                end else begin
                  word_idx   <= word_idx + 1'b1;
                  o_reg_addr <= ADDR_WIDTH'(word_idx + 1'b1);
                end
                state <= S_FETCH;
              end
              default: begin
                if (word_idx == IDX_W'(N_MEM - 1)) begin
                  o_done <= 1'b1;
                  o_busy <= 1'b0;
                  state  <= S_DONE;
                end else begin
                  word_idx   <= word_idx + 1'b1;
                  o_mem_addr <= ADDR_WIDTH'(word_idx + 1'b1);
                  state      <= S_FETCH;
                end
              end
            endcase
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Bench for debug_dump_sequencer: sync-read regfile/memory models and a UART model with slow tx_done.
`timescale 1ns/1ps
module tb_debug_dump_sequencer;
  localparam int NR = 32;
  localparam int NM = 32;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_pc;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data;
  logic [4:0]  o_mem_addr;
  logic [31:0] i_mem_data;
  logic        i_tx_available;
  logic        i_tx_done;
  logic        o_tx_signal;
  logic [7:0]  o_tx_byte;
  logic        o_busy;
  logic        o_done;

  debug_dump_sequencer dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_pc(i_pc),
    .o_reg_addr(o_reg_addr), .i_reg_data(i_reg_data),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data),
    .i_tx_available(i_tx_available), .i_tx_done(i_tx_done),
    .o_tx_signal(o_tx_signal), .o_tx_byte(o_tx_byte),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clock = ~i_clock;

  logic [31:0] reg_model [NR];
  logic [31:0] mem_model [NM];

  always @(posedge i_clock) begin
    i_reg_data <= reg_model[o_reg_addr];
    i_mem_data <= mem_model[o_mem_addr];
  end

  // UART: busy after a strobe, tx_done pulse about 12 cycles later.
  logic uart_busy, uart_done, avail_en, inj_done;
  int   uart_cnt;
  always @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      uart_busy <= 1'b0;
      uart_done <= 1'b0;
      uart_cnt  <= 0;
    end else begin
      uart_done <= 1'b0;
      if (o_tx_signal && !uart_busy) begin
        uart_busy <= 1'b1;
        uart_cnt  <= 12;
      end else if (uart_busy) begin
        if (uart_cnt == 1) begin
          uart_done <= 1'b1;
          uart_busy <= 1'b0;
        end
        uart_cnt <= uart_cnt - 1;
      end
    end
  end
  assign i_tx_available = avail_en & ~uart_busy;
  assign i_tx_done      = uart_done | inj_done;

  logic [7:0] cap_q[$];
  logic [7:0] first_q[$];
  logic [7:0] exp_q[$];
  int         done_cnt;

  always @(negedge i_clock) begin
    if (o_tx_signal) cap_q.push_back(o_tx_byte);
    if (o_done) done_cnt++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_strobes(input int n, input string tag);
    int c = 0;
    while (cap_q.size() < n && c < 10000) begin
      @(negedge i_clock);
      c++;
    end
    check(tag, 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (o_done !== 1'b1 && c < 10000) begin
      @(negedge i_clock);
      c++;
    end
    check(tag, 32'(o_done), 32'd1);
  endtask

  typedef struct {
    int         pos;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[28];

  initial begin
    int c;
    logic [7:0] held;
    int bad_byte;

    vecs = '{
      '{0, 8'h34}, '{1, 8'h00}, '{2, 8'h00}, '{3, 8'h00},
      '{4, 8'h00}, '{5, 8'h00}, '{6, 8'h00}, '{7, 8'h00},
      '{8, 8'h01}, '{9, 8'h00}, '{10, 8'h00}, '{11, 8'h00},
      '{24, 8'hDD}, '{25, 8'h05}, '{26, 8'h00}, '{27, 8'h00},
      '{132, 8'h00}, '{133, 8'h01}, '{134, 8'h00}, '{135, 8'h00},
      '{140, 8'hDD}, '{141, 8'hCC}, '{142, 8'hBB}, '{143, 8'hAA},
      '{256, 8'h1F}, '{257, 8'h01}, '{258, 8'h00}, '{259, 8'h00}
    };
    for (int n = 0; n < NR; n++) reg_model[n] = 32'(n);
    for (int n = 0; n < NM; n++) mem_model[n] = 32'h100 + 32'(n);
    reg_model[5] = 32'h0000_05DD;
    mem_model[2] = 32'hAABB_CCDD;

    i_reset = 1'b0; i_start = 1'b0; i_pc = '0;
    avail_en = 1'b1; inj_done = 1'b0; done_cnt = 0;
    repeat (3) @(negedge i_clock);
    check("rst_tx_signal", 32'(o_tx_signal), 0);
    check("rst_tx_byte", 32'(o_tx_byte), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_done), 0);
    i_reset = 1'b1;
    @(negedge i_clock);

    // Reset in the middle of a dump, while byte 5 is in flight.
    i_pc = 32'h1234_5678; i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    wait_strobes(5, "mid_reset_reach");
    i_reset = 1'b0;
    #1;
    check("mid_rst_tx_signal", 32'(o_tx_signal), 0);
    check("mid_rst_tx_byte", 32'(o_tx_byte), 0);
    check("mid_rst_reg_addr", 32'(o_reg_addr), 0);
    check("mid_rst_mem_addr", 32'(o_mem_addr), 0);
    check("mid_rst_busy", 32'(o_busy), 0);
    check("mid_rst_done", 32'(o_done), 0);
    repeat (3) @(negedge i_clock);
    i_reset = 1'b1;
    cap_q.delete();
    done_cnt = 0;
    repeat (100) @(negedge i_clock);
    check("post_rst_no_strobe", 32'(cap_q.size()), 0);
    check("post_rst_busy", 32'(o_busy), 0);

    // Full dump with injected disturbances.
    i_pc = 32'h0000_0034; i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    check("start_busy", 32'(o_busy), 1);

    wait_strobes(8, "reach_word1_end");
    i_pc = 32'hFFFF_FFFF; i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    c = 0;
    while (uart_done !== 1'b1 && c < 100) begin
      @(negedge i_clock);
      c++;
    end
    check("uart_done_seen", 32'(uart_done), 1);
    @(negedge i_clock);
    @(negedge i_clock);
    inj_done = 1'b1;
    @(negedge i_clock);
    inj_done = 1'b0;

    // Backpressure on reg[5] byte 0.
    wait_strobes(24, "reach_reg5");
    avail_en = 1'b0;
    repeat (20) @(negedge i_clock);
    held = o_tx_byte;
    check("bp_held_byte", 32'(held), 32'hDD);
    bad_byte = 0;
    for (int k = 0; k < 50; k++) begin
      inj_done = (k == 25);
      i_start  = (k == 10);
      @(negedge i_clock);
      if (o_tx_byte !== held) bad_byte++;
    end
    inj_done = 1'b0; i_start = 1'b0;
    check("bp_no_strobe", 32'(cap_q.size()), 24);
    check("bp_byte_stable_errs", 32'(bad_byte), 0);
    check("bp_busy", 32'(o_busy), 1);
    avail_en = 1'b1;
    repeat (5) @(negedge i_clock);
    check("bp_one_strobe", 32'(cap_q.size()), 25);

    // DONE cycle: start here is ignored, start in the following IDLE cycle is taken.
    wait_done("dump1_done");
    check("done_cycle_busy", 32'(o_busy), 0);
    i_pc = 32'hDEAD_BEEF; i_start = 1'b1;
    first_q = cap_q;
    cap_q.delete();
    @(negedge i_clock);
    check("done_single_pulse", 32'(o_done), 0);
    i_pc = 32'hCAFE_F00D;
    @(negedge i_clock);
    i_start = 1'b0;
    check("b2b_busy", 32'(o_busy), 1);

    check("dump1_count", 32'(first_q.size()), 260);
    for (int v = 0; v < 28; v++)
      check($sformatf("vec_pos%0d", vecs[v].pos), 32'(first_q[vecs[v].pos]), 32'(vecs[v].exp));

    exp_q.delete();
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(32'h34 >> (8 * b)));
    for (int n = 0; n < NR; n++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(reg_model[n] >> (8 * b)));
    for (int n = 0; n < NM; n++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(mem_model[n] >> (8 * b)));
    c = 0;
    for (int i = 0; i < 260; i++)
      if (first_q[i] !== exp_q[i]) c++;
    check("dump1_byte_errs", 32'(c), 0);

    wait_done("dump2_done");
    @(negedge i_clock);
    check("dump2_count", 32'(cap_q.size()), 260);
    check("dump2_b0", 32'(cap_q[0]), 32'h0D);
    check("dump2_b1", 32'(cap_q[1]), 32'hF0);
    check("dump2_b2", 32'(cap_q[2]), 32'hFE);
    check("dump2_b3", 32'(cap_q[3]), 32'hCA);
    check("done_pulses", 32'(done_cnt), 2);
    check("final_busy", 32'(o_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
